// File: rtl/pcie_req_arb.sv
// pcie_req_arb: round-robin MRd/MWr arbiter with tag allocation; m_* requesters -> req_* channel, cpl_* completions -> r_* owner by tag
package pcie_pkg;
  typedef enum logic [1:0] {TLP_MRd = 2'd0, TLP_MWr = 2'd1} tlp_type_e;
endpackage

module pcie_req_arb import pcie_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              m_valid,
  output logic [NREQ-1:0]              m_ready,
  input  logic [NREQ-1:0]              m_is_rd,
  input  logic [NREQ*ADDR_W-1:0]       m_addr,
  input  logic [NREQ*DATA_W-1:0]       m_data,
  output logic                         req_valid,
  input  logic                         req_ready,
  output tlp_type_e                    req_type,
  output logic [ADDR_W-1:0]            req_addr,
  output logic [DATA_W-1:0]            req_data,
  output logic [7:0]                   req_tag,
  input  logic                         cpl_valid,
  output logic                         cpl_ready,
  input  logic [7:0]                   cpl_tag,
  input  logic [DATA_W-1:0]            cpl_data,
  input  logic [2:0]                   cpl_status,
  output logic [NREQ-1:0]              r_valid,
  output logic [DATA_W-1:0]            r_data,
  output logic [2:0]                   r_status,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         err_unexp_tag
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT+1);
  logic [MAX_OUT-1:0] busy_q, busy_d;
  logic [IW-1:0] owner_q [MAX_OUT];
  logic [IW-1:0] rr_q, gnt, cpl_owner;
  logic [TW-1:0] free_tag;
  logic gnt_v, load, free_avail, alloc, hit;
  logic req_valid_q, err_q;
  tlp_type_e req_type_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q, r_data_q;
  logic [7:0] req_tag_q;
  logic [NREQ-1:0] r_valid_q;
  logic [2:0] r_status_q;
  logic [OW-1:0] out_q;
  assign load       = !req_valid_q || req_ready;
  assign free_avail = !(&busy_q);
  assign alloc      = load && gnt_v && m_is_rd[gnt];
  assign m_ready    = (load && gnt_v && !rst) ? NREQ'(1) << gnt : '0;
  assign cpl_ready  = 1'b1;
  always_comb begin
    gnt = rr_q;
    gnt_v = 1'b0;
    for (int k = NREQ-1; k >= 0; k--)
      if (m_valid[(int'(rr_q) + k) % NREQ] && (!m_is_rd[(int'(rr_q) + k) % NREQ] || free_avail)) begin
        gnt = IW'((int'(rr_q) + k) % NREQ);
        gnt_v = 1'b1;
      end
    free_tag = '0;
    for (int t = MAX_OUT-1; t >= 0; t--)
      if (!busy_q[t]) free_tag = TW'(t);
    hit = 1'b0;
    cpl_owner = '0;
    for (int t = 0; t < MAX_OUT; t++)
      if (cpl_valid && int'(cpl_tag) == t && busy_q[t]) begin
        hit = 1'b1;
        cpl_owner = owner_q[t];
      end
    busy_d = busy_q;
    if (hit) busy_d[cpl_tag[TW-1:0]] = 1'b0;
    if (alloc) busy_d[free_tag] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q      <= '0;
      rr_q        <= '0;
      out_q       <= '0;
      req_valid_q <= 1'b0;
      req_type_q  <= TLP_MRd;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      r_valid_q   <= '0;
      r_data_q    <= '0;
      r_status_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      out_q     <= out_q + OW'(alloc) - OW'(hit);
      r_valid_q <= hit ? NREQ'(1) << cpl_owner : '0;
      err_q     <= cpl_valid && !hit;
      if (hit) begin
        r_data_q   <= cpl_data;
        r_status_q <= cpl_status;
      end
      if (load) req_valid_q <= gnt_v;
      if (load && gnt_v) begin
        rr_q       <= gnt == IW'(NREQ-1) ? '0 : gnt + 1'b1;
        req_type_q <= m_is_rd[gnt] ? TLP_MRd : TLP_MWr;
        req_addr_q <= m_addr[gnt*ADDR_W +: ADDR_W];
        req_data_q <= m_is_rd[gnt] ? '0 : m_data[gnt*DATA_W +: DATA_W];
        req_tag_q  <= m_is_rd[gnt] ? 8'(free_tag) : '0;
      end
    end
  always_ff @(posedge clk)
    if (alloc) owner_q[free_tag] <= gnt;
  assign req_valid     = req_valid_q;
  assign req_type      = req_type_q;
  assign req_addr      = req_addr_q;
  assign req_data      = req_data_q;
  assign req_tag       = req_tag_q;
  assign r_valid       = r_valid_q;
  assign r_data        = r_data_q;
  assign r_status      = r_status_q;
  assign outstanding   = out_q;
  assign err_unexp_tag = err_q;
endmodule

// File: tb/tb_pcie_req_arb.sv
// tb_pcie_req_arb: table-driven and directed-sequence self-checking bench for pcie_req_arb
module tb_pcie_req_arb;
  import pcie_pkg::*;
  localparam int NREQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 8;
  typedef struct {
    logic [3:0] mv, rd;
    logic rdy, cv;
    logic [7:0] ctag;
    logic [31:0] cdata;
    logic [2:0] cst;
    logic [3:0] e_mr;
    logic e_rv;
    int e_sel;
    logic e_wr;
    logic [7:0] e_tag;
    logic [3:0] e_r;
    logic [31:0] e_rd;
    logic [2:0] e_rs;
    logic [3:0] e_out;
    logic e_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] m_valid, m_ready, m_is_rd, r_valid;
  logic [NREQ*AW-1:0] m_addr;
  logic [NREQ*DW-1:0] m_data;
  logic req_valid, req_ready, cpl_valid, cpl_ready, err_unexp_tag;
  tlp_type_e req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data, cpl_data, r_data;
  logic [7:0] req_tag, cpl_tag;
  logic [2:0] cpl_status, r_status;
  logic [3:0] outstanding;
  int pass_n = 0;
  int total_n = 0;
  vec_t tbl[$];
  pcie_req_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_is_rd(m_is_rd),
    .m_addr(m_addr), .m_data(m_data), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
    .cpl_status(cpl_status), .r_valid(r_valid), .r_data(r_data), .r_status(r_status),
    .outstanding(outstanding), .err_unexp_tag(err_unexp_tag)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [31:0] data_of(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction
  function automatic vec_t v(input logic [3:0] mv, rd, input logic cv, input logic [7:0] ctag,
                             input logic [31:0] cdata, input logic [2:0] cst, input logic [3:0] e_mr,
                             input logic e_rv, input int e_sel, input logic e_wr, input logic [7:0] e_tag,
                             input logic [3:0] e_r, input logic [31:0] e_rd, input logic [2:0] e_rs,
                             input logic [3:0] e_out, input logic e_err);
    vec_t t;
    t.mv = mv; t.rd = rd; t.rdy = 1'b1; t.cv = cv; t.ctag = ctag; t.cdata = cdata; t.cst = cst;
    t.e_mr = e_mr; t.e_rv = e_rv; t.e_sel = e_sel; t.e_wr = e_wr; t.e_tag = e_tag;
    t.e_r = e_r; t.e_rd = e_rd; t.e_rs = e_rs; t.e_out = e_out; t.e_err = e_err;
    return t;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic apply(input vec_t t, input int n);
    @(negedge clk);
    m_valid = t.mv; m_is_rd = t.rd; req_ready = t.rdy;
    cpl_valid = t.cv; cpl_tag = t.ctag; cpl_data = t.cdata; cpl_status = t.cst;
    #1 chk($sformatf("v%0d m_ready", n), m_ready, t.e_mr);
    @(posedge clk);
    #1 chk($sformatf("v%0d req_valid", n), req_valid, t.e_rv);
    if (t.e_rv) begin
      chk($sformatf("v%0d req_addr", n), req_addr, addr_of(t.e_sel));
      chk($sformatf("v%0d req_type", n), req_type, t.e_wr ? TLP_MWr : TLP_MRd);
      chk($sformatf("v%0d req_data", n), req_data, t.e_wr ? data_of(t.e_sel) : 32'h0);
      chk($sformatf("v%0d req_tag", n), req_tag, t.e_tag);
    end
    chk($sformatf("v%0d r_valid", n), r_valid, t.e_r);
    if (t.e_r != 0) begin
      chk($sformatf("v%0d r_data", n), r_data, t.e_rd);
      chk($sformatf("v%0d r_status", n), r_status, t.e_rs);
    end
    chk($sformatf("v%0d outstanding", n), outstanding, t.e_out);
    chk($sformatf("v%0d err", n), err_unexp_tag, t.e_err);
  endtask
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      m_addr[i*AW +: AW] = addr_of(i);
      m_data[i*DW +: DW] = data_of(i);
    end
    rst = 1'b1; m_valid = '0; m_is_rd = '0; req_ready = 1'b1;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_data = '0; cpl_status = '0;
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(4'hF, 4'h0, 0, 0, 0, 0, 4'(1 << (i % 4)), 1, i % 4, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(v(4'h4, 4'h4, 0, 0, 0, 0, 4'h4, 1, 2, 0, 8'(k), 0, 0, 0, 4'(k + 1), 0));
    tbl.push_back(v(4'h4, 4'h4, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
    tbl.push_back(v(4'h6, 4'h4, 0, 0, 0, 0, 4'h2, 1, 1, 1, 0, 0, 0, 0, 8, 0));
    tbl.push_back(v(4'h4, 4'h4, 1, 3, 32'h1234_5678, 3'd2, 4'h0, 0, 0, 0, 0, 4'h4, 32'h1234_5678, 3'd2, 7, 0));
    tbl.push_back(v(4'h4, 4'h4, 0, 0, 0, 0, 4'h4, 1, 2, 0, 3, 0, 0, 0, 8, 0));
    tbl.push_back(v(4'h0, 4'h0, 1, 5, 32'hAABB_CCDD, 0, 4'h0, 0, 0, 0, 0, 4'h4, 32'hAABB_CCDD, 0, 7, 0));
    tbl.push_back(v(4'h0, 4'h0, 1, 5, 32'h1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 7, 1));
    tbl.push_back(v(4'h0, 4'h0, 1, 200, 32'h2, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 7, 1));
    tbl.push_back(v(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 7, 0));
    tbl.push_back(v(4'h4, 4'h4, 1, 0, 32'h55, 0, 4'h4, 1, 2, 0, 5, 4'h4, 32'h55, 0, 7, 0));
    tbl.push_back(v(4'h4, 4'h4, 0, 0, 0, 0, 4'h4, 1, 2, 0, 0, 0, 0, 0, 8, 0));
    tbl.push_back(v(4'hC, 4'h4, 0, 0, 0, 0, 4'h8, 1, 3, 1, 0, 0, 0, 0, 8, 0));
    repeat (2) @(negedge clk);
    chk("rst req_valid", req_valid, 0);
    chk("rst cpl_ready", cpl_ready, 1);
    chk("rst outstanding", outstanding, 0);
    chk("rst req_type", req_type, 0);
    chk("rst r_valid", r_valid, 0);
    rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i], i);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst req_valid", req_valid, 0);
    chk("midrst outstanding", outstanding, 0);
    @(negedge clk);
    rst = 1'b0; m_valid = 4'h3; m_is_rd = 4'h0; req_ready = 1'b0;
    #1 chk("bp first m_ready", m_ready, 4'h1);
    @(posedge clk);
    #1 chk("bp first req_addr", req_addr, addr_of(0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 chk($sformatf("bp%0d m_ready", c), m_ready, 4'h0);
      @(posedge clk);
      #1 chk($sformatf("bp%0d req_valid", c), req_valid, 1);
      chk($sformatf("bp%0d req_addr", c), req_addr, addr_of(0));
      chk($sformatf("bp%0d req_data", c), req_data, data_of(0));
      chk($sformatf("bp%0d req_type", c), req_type, TLP_MWr);
      chk($sformatf("bp%0d req_tag", c), req_tag, 0);
    end
    @(negedge clk);
    req_ready = 1'b1;
    #1 chk("bp release m_ready", m_ready, 4'h2);
    @(posedge clk);
    #1 chk("bp release req_addr", req_addr, addr_of(1));
    @(negedge clk);
    m_valid = 4'h0;
    @(posedge clk);
    #1 chk("bp drain req_valid", req_valid, 0);
    @(negedge clk);
    m_valid = 4'h1; m_is_rd = 4'h1;
    repeat (3) @(posedge clk);
    #1 chk("pre-rst outstanding", outstanding, 3);
    chk("pre-rst req_tag", req_tag, 2);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst3 m_ready", m_ready, 0);
    chk("rst3 req_valid", req_valid, 0);
    chk("rst3 outstanding", outstanding, 0);
    chk("rst3 req_addr", req_addr, 0);
    chk("rst3 req_tag", req_tag, 0);
    chk("rst3 cpl_ready", cpl_ready, 1);
    @(negedge clk);
    rst = 1'b0; m_valid = 4'h0; cpl_valid = 1'b1; cpl_tag = 8'd1;
    @(posedge clk);
    #1 chk("late cpl err", err_unexp_tag, 1);
    chk("late cpl r_valid", r_valid, 0);
    chk("late cpl outstanding", outstanding, 0);
    @(negedge clk);
    cpl_valid = 1'b0;
    @(posedge clk);
    #1 chk("late cpl err clear", err_unexp_tag, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
